alu_cdb_unit: RTL and testbench

- Execution-side responder for the reservation-station issue interface. Accepts one issued op per cycle (op, ic, qd, vs, vt, imm, pc), computes the RV32I integer/branch result, and queues it.
- Broadcasts the queued result on the CDB toward the ROB and reservation stations, under a grant from the CDB arbiter.
- The RS has no ready signal, so this block never back-pressures directly. It exposes an almost-full flag that the top level uses to drive RS `en` low.

---
 rtl/alu_cdb_unit_pkg.sv | 48 ++++
 rtl/alu_cdb_unit_calc.sv | 113 +++++++++++
 rtl/alu_cdb_unit.sv | 157 +++++++++++++++
 tb/tb_alu_cdb_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cdb_unit_pkg.sv
// Shared definitions for the ALU/CDB execution unit: default widths,
// operation codes and the layout of one queued CDB entry.
package alu_cdb_unit_pkg;

    localparam int DEF_DAT_W   = 32;
    localparam int DEF_ADR_W   = 32;
    localparam int DEF_ROB_BIT = 4;
    localparam int DEF_OP_W    = 5;
    localparam int DEF_QD      = 4;

    // Operation codes issued by the reservation station.
    typedef enum logic [DEF_OP_W-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_LUI    = 5'd10,
        OP_AUIPC  = 5'd11,
        OP_JAL    = 5'd12,
        OP_JALR   = 5'd13,
        OP_BEQ    = 5'd14,
        OP_BNE    = 5'd15,
        OP_BLT    = 5'd16,
        OP_BGE    = 5'd17,
        OP_BLTU   = 5'd18,
        OP_BGEU   = 5'd19,
        OP_MUL    = 5'd20,
        OP_MULH   = 5'd21,
        OP_MULHSU = 5'd22,
        OP_MULHU  = 5'd23
    } alu_op_e;

    // Field layout of one result-queue entry at default widths.
    typedef struct packed {
        logic [DEF_ROB_BIT-1:0] qd;
        logic [DEF_DAT_W-1:0]   v;
        logic                   br;
        logic                   taken;
        logic [DEF_ADR_W-1:0]   tgt;
    } cdb_entry_t;

endpackage

// File: rtl/alu_cdb_unit_calc.sv
// alu_calc: purely combinational RV32I integer/branch evaluation.
// Build option: define ALU_MUL_EN to add MUL/MULH/MULHSU/MULHU on codes 20-23;
// without it those codes yield value 0, br 0 and no multiplier exists.
module alu_calc
    import alu_cdb_unit_pkg::*;
#(
    parameter int DAT_W = DEF_DAT_W,
    parameter int ADR_W = DEF_ADR_W,
    parameter int OP_W  = DEF_OP_W
)(
    input  logic [OP_W-1:0]  i_op,
    input  logic             i_ic,
    input  logic [DAT_W-1:0] i_vs,
    input  logic [DAT_W-1:0] i_vt,
    input  logic [DAT_W-1:0] i_imm,
    input  logic [ADR_W-1:0] i_pc,
    output logic [DAT_W-1:0] o_v,
    output logic             o_br,
    output logic             o_taken,
    output logic [ADR_W-1:0] o_tgt
);

    localparam int SH_W = $clog2(DAT_W);

    logic [DAT_W-1:0] w_a;
    logic [DAT_W-1:0] w_b;
    logic [SH_W-1:0]  w_shamt;
    logic [ADR_W-1:0] w_pc4;
    logic [ADR_W-1:0] w_pc_imm;
    logic [DAT_W-1:0] w_jalr;
    logic             w_eq;
    logic             w_lt;
    logic             w_ltu;
    logic             w_slt;
    logic             w_sltu;

    assign w_a      = i_vs;
    assign w_b      = i_ic ? i_vt : i_imm;
    assign w_shamt  = w_b[SH_W-1:0];
    assign w_pc4    = i_pc + ADR_W'(32'd4);
    assign w_pc_imm = i_pc + ADR_W'(i_imm);
    assign w_jalr   = (i_vs + i_imm) & ~(DAT_W'(1'b1));
    // Branch comparisons always use rs2, independent of the ic select.
    assign w_eq     = (i_vs == i_vt);
    assign w_lt     = ($signed(i_vs) < $signed(i_vt));
    assign w_ltu    = (i_vs < i_vt);
    // Set-less-than compares against the selected second operand.
    assign w_slt    = ($signed(w_a) < $signed(w_b));
    assign w_sltu   = (w_a < w_b);

`ifdef ALU_MUL_EN
    logic [2*DAT_W-1:0] w_mul_uu;
    logic [2*DAT_W-1:0] w_mul_ss;
    logic [2*DAT_W-1:0] w_mul_su;

    assign w_mul_uu = {{DAT_W{1'b0}}, w_a} * {{DAT_W{1'b0}}, w_b};
    assign w_mul_ss = $signed({{DAT_W{w_a[DAT_W-1]}}, w_a}) * $signed({{DAT_W{w_b[DAT_W-1]}}, w_b});
    assign w_mul_su = {{DAT_W{w_a[DAT_W-1]}}, w_a} * {{DAT_W{1'b0}}, w_b};
`endif

    // Select result value and redirect information for the issued op.
    always_comb begin
        o_v     = {DAT_W{1'b0}};
        o_br    = 1'b0;
        o_taken = 1'b0;
        o_tgt   = {ADR_W{1'b0}};
        case (i_op)
            OP_ADD:   o_v = w_a + w_b;
            OP_SUB:   o_v = w_a - w_b;
            OP_SLL:   o_v = w_a << w_shamt;
            OP_SLT:   o_v = {{(DAT_W-1){1'b0}}, w_slt};
            OP_SLTU:  o_v = {{(DAT_W-1){1'b0}}, w_sltu};
            OP_XOR:   o_v = w_a ^ w_b;
            OP_SRL:   o_v = w_a >> w_shamt;
            OP_SRA:   o_v = DAT_W'($signed(w_a) >>> w_shamt);
            OP_OR:    o_v = w_a | w_b;
            OP_AND:   o_v = w_a & w_b;
            OP_LUI:   o_v = i_imm;
            OP_AUIPC: o_v = DAT_W'(w_pc_imm);
            OP_JAL: begin
                o_v     = DAT_W'(w_pc4);
                o_br    = 1'b1;
                o_taken = 1'b1;
                o_tgt   = w_pc_imm;
            end
            OP_JALR: begin
                o_v     = DAT_W'(w_pc4);
                o_br    = 1'b1;
                o_taken = 1'b1;
                o_tgt   = ADR_W'(w_jalr);
            end
            OP_BEQ:  begin o_br = 1'b1; o_taken = w_eq;   o_tgt = w_eq   ? w_pc_imm : w_pc4; end
            OP_BNE:  begin o_br = 1'b1; o_taken = !w_eq;  o_tgt = !w_eq  ? w_pc_imm : w_pc4; end
            OP_BLT:  begin o_br = 1'b1; o_taken = w_lt;   o_tgt = w_lt   ? w_pc_imm : w_pc4; end
            OP_BGE:  begin o_br = 1'b1; o_taken = !w_lt;  o_tgt = !w_lt  ? w_pc_imm : w_pc4; end
            OP_BLTU: begin o_br = 1'b1; o_taken = w_ltu;  o_tgt = w_ltu  ? w_pc_imm : w_pc4; end
            OP_BGEU: begin o_br = 1'b1; o_taken = !w_ltu; o_tgt = !w_ltu ? w_pc_imm : w_pc4; end
`ifdef ALU_MUL_EN
            OP_MUL:    o_v = w_mul_uu[DAT_W-1:0];
            OP_MULH:   o_v = w_mul_ss[2*DAT_W-1:DAT_W];
            OP_MULHSU: o_v = w_mul_su[2*DAT_W-1:DAT_W];
            OP_MULHU:  o_v = w_mul_uu[2*DAT_W-1:DAT_W];
`endif
            default: begin
                o_v     = {DAT_W{1'b0}};
                o_br    = 1'b0;
                o_taken = 1'b0;
                o_tgt   = {ADR_W{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/alu_cdb_unit.sv
// alu_cdb_unit: accepts one issued op per cycle, evaluates it through
// alu_calc, queues the result and broadcasts the queue head on the CDB
// under arbiter grant. Optional multiply ops are enabled by ALU_MUL_EN
// (handled inside alu_calc).
module alu_cdb_unit
    import alu_cdb_unit_pkg::*;
#(
    parameter int DAT_W   = DEF_DAT_W,
    parameter int ADR_W   = DEF_ADR_W,
    parameter int ROB_BIT = DEF_ROB_BIT,
    parameter int OP_W    = DEF_OP_W,
    parameter int QD      = DEF_QD
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               br_flag,
    input  logic               alu_en_i,
    input  logic [OP_W-1:0]    alu_op_i,
    input  logic               alu_ic_i,
    input  logic [ROB_BIT-1:0] alu_qd_i,
    input  logic [DAT_W-1:0]   alu_vs_i,
    input  logic [DAT_W-1:0]   alu_vt_i,
    input  logic [DAT_W-1:0]   alu_imm_i,
    input  logic [ADR_W-1:0]   alu_pc_i,
    output logic               alu_full_o,
    input  logic               cdb_gnt_i,
    output logic               cdb_en_o,
    output logic [ROB_BIT-1:0] cdb_q_o,
    output logic [DAT_W-1:0]   cdb_v_o,
    output logic               cdb_br_o,
    output logic               cdb_taken_o,
    output logic [ADR_W-1:0]   cdb_tgt_o,
    output logic               ovf_o
);

    localparam int PW = $clog2(QD);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX = CW'(QD);
    localparam logic [CW-1:0] CNT_AF  = CW'(QD - 1);

    // Computed result for the op currently presented by the RS.
    logic [DAT_W-1:0] w_v;
    logic             w_br;
    logic             w_taken;
    logic [ADR_W-1:0] w_tgt;

    // Queue storage and pointers.
    logic [ROB_BIT-1:0] r_q_mem     [QD];
    logic [DAT_W-1:0]   r_v_mem     [QD];
    logic               r_br_mem    [QD];
    logic               r_taken_mem [QD];
    logic [ADR_W-1:0]   r_tgt_mem   [QD];
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    logic               r_ovf;

    logic w_nonempty;
    logic w_full;
    logic w_push_req;
    logic w_pop;
    logic w_push;
    logic w_drop;

    alu_calc #(
        .DAT_W (DAT_W),
        .ADR_W (ADR_W),
        .OP_W  (OP_W)
    ) u_calc (
        .i_op    (alu_op_i),
        .i_ic    (alu_ic_i),
        .i_vs    (alu_vs_i),
        .i_vt    (alu_vt_i),
        .i_imm   (alu_imm_i),
        .i_pc    (alu_pc_i),
        .o_v     (w_v),
        .o_br    (w_br),
        .o_taken (w_taken),
        .o_tgt   (w_tgt)
    );

    assign w_nonempty = (r_count != {CW{1'b0}});
    assign w_full     = (r_count == CNT_MAX);
    assign w_push_req = en && alu_en_i;
    assign w_pop      = en && w_nonempty && cdb_gnt_i;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    // Pointer, occupancy and sticky-overflow bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
            r_ovf   <= 1'b0;
        end else if (br_flag) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_ONE;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Write the computed result into the tail entry on an accepted push.
    always_ff @(posedge clk) begin
        if (!rst && !br_flag && w_push) begin
            r_q_mem[r_tail]     <= alu_qd_i;
            r_v_mem[r_tail]     <= w_v;
            r_br_mem[r_tail]    <= w_br;
            r_taken_mem[r_tail] <= w_taken;
            r_tgt_mem[r_tail]   <= w_tgt;
        end
    end

    // Present the head entry on the CDB, forcing zeros while the queue is empty.
    always_comb begin
        cdb_en_o    = 1'b0;
        cdb_q_o     = {ROB_BIT{1'b0}};
        cdb_v_o     = {DAT_W{1'b0}};
        cdb_br_o    = 1'b0;
        cdb_taken_o = 1'b0;
        cdb_tgt_o   = {ADR_W{1'b0}};
        if (w_nonempty) begin
            cdb_en_o    = 1'b1;
            cdb_q_o     = r_q_mem[r_head];
            cdb_v_o     = r_v_mem[r_head];
            cdb_br_o    = r_br_mem[r_head];
            cdb_taken_o = r_taken_mem[r_head];
            cdb_tgt_o   = r_tgt_mem[r_head];
        end else begin
            cdb_en_o    = 1'b0;
        end
    end

    // Almost-full leaves one entry of slack for the RS stall, which lags a cycle.
    assign alu_full_o = (r_count >= CNT_AF);
    assign ovf_o      = r_ovf;

endmodule

// File: tb/tb_alu_cdb_unit.sv
// Directed self-checking bench for alu_cdb_unit (default parameters).
module tb_alu_cdb_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        br_flag;
    logic        alu_en_i;
    logic [4:0]  alu_op_i;
    logic        alu_ic_i;
    logic [3:0]  alu_qd_i;
    logic [31:0] alu_vs_i;
    logic [31:0] alu_vt_i;
    logic [31:0] alu_imm_i;
    logic [31:0] alu_pc_i;
    logic        alu_full_o;
    logic        cdb_gnt_i;
    logic        cdb_en_o;
    logic [3:0]  cdb_q_o;
    logic [31:0] cdb_v_o;
    logic        cdb_br_o;
    logic        cdb_taken_o;
    logic [31:0] cdb_tgt_o;
    logic        ovf_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    alu_cdb_unit dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .br_flag     (br_flag),
        .alu_en_i    (alu_en_i),
        .alu_op_i    (alu_op_i),
        .alu_ic_i    (alu_ic_i),
        .alu_qd_i    (alu_qd_i),
        .alu_vs_i    (alu_vs_i),
        .alu_vt_i    (alu_vt_i),
        .alu_imm_i   (alu_imm_i),
        .alu_pc_i    (alu_pc_i),
        .alu_full_o  (alu_full_o),
        .cdb_gnt_i   (cdb_gnt_i),
        .cdb_en_o    (cdb_en_o),
        .cdb_q_o     (cdb_q_o),
        .cdb_v_o     (cdb_v_o),
        .cdb_br_o    (cdb_br_o),
        .cdb_taken_o (cdb_taken_o),
        .cdb_tgt_o   (cdb_tgt_o),
        .ovf_o       (ovf_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic ic, input logic [3:0] qd,
                         input logic [31:0] vs, input logic [31:0] vt,
                         input logic [31:0] imm, input logic [31:0] pc);
        alu_en_i  = 1'b1;
        alu_op_i  = op;
        alu_ic_i  = ic;
        alu_qd_i  = qd;
        alu_vs_i  = vs;
        alu_vt_i  = vt;
        alu_imm_i = imm;
        alu_pc_i  = pc;
        tick();
        alu_en_i  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; br_flag = 1'b0; alu_en_i = 1'b0; alu_op_i = 5'd0;
        alu_ic_i = 1'b0; alu_qd_i = 4'd0; alu_vs_i = 32'd0; alu_vt_i = 32'd0;
        alu_imm_i = 32'd0; alu_pc_i = 32'd0; cdb_gnt_i = 1'b1;
        do_reset();

        chk("rst_en",   {31'd0, cdb_en_o},   32'd0);
        chk("rst_full", {31'd0, alu_full_o}, 32'd0);
        chk("rst_ovf",  {31'd0, ovf_o},      32'd0);
        chk("rst_v",    cdb_v_o,             32'd0);

        // ADD with one-cycle latency, then popped under grant.
        issue(5'd0, 1'b1, 4'd3, 32'd5, 32'd7, 32'd99, 32'd0);
        chk("add_en", {31'd0, cdb_en_o}, 32'd1);
        chk("add_q",  {28'd0, cdb_q_o},  32'd3);
        chk("add_v",  cdb_v_o,           32'd12);
        chk("add_br", {31'd0, cdb_br_o}, 32'd0);
        tick();
        chk("add_pop", {31'd0, cdb_en_o}, 32'd0);

        // Branches: comparison uses vt even with ic=0.
        issue(5'd16, 1'b0, 4'd5, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
        chk("blt_br",  {31'd0, cdb_br_o},    32'd1);
        chk("blt_tk",  {31'd0, cdb_taken_o}, 32'd1);
        chk("blt_tgt", cdb_tgt_o,            32'h120);
        chk("blt_q",   {28'd0, cdb_q_o},     32'd5);
        issue(5'd19, 1'b0, 4'd6, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100);
        chk("bgeu_tk",  {31'd0, cdb_taken_o}, 32'd1);
        chk("bgeu_tgt", cdb_tgt_o,            32'h120);
        issue(5'd14, 1'b0, 4'd7, 32'd2, 32'd3, 32'h20, 32'h100);
        chk("beq_tk",  {31'd0, cdb_taken_o}, 32'd0);
        chk("beq_tgt", cdb_tgt_o,            32'h104);
        chk("beq_v",   cdb_v_o,              32'd0);

        // Jumps.
        issue(5'd13, 1'b0, 4'd8, 32'h203, 32'd0, 32'd4, 32'h40);
        chk("jalr_v",   cdb_v_o,              32'h44);
        chk("jalr_tk",  {31'd0, cdb_taken_o}, 32'd1);
        chk("jalr_tgt", cdb_tgt_o,            32'h206);
        issue(5'd12, 1'b0, 4'd9, 32'd0, 32'd0, 32'h100, 32'h200);
        chk("jal_v",   cdb_v_o,   32'h204);
        chk("jal_tgt", cdb_tgt_o, 32'h300);

        // Integer ops.
        issue(5'd1, 1'b0, 4'd1, 32'd3, 32'd0, 32'd5, 32'd0);
        chk("sub_imm", cdb_v_o, 32'hFFFF_FFFE);
        issue(5'd7, 1'b1, 4'd1, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
        chk("sra", cdb_v_o, 32'hF800_0000);
        issue(5'd6, 1'b1, 4'd1, 32'h8000_0000, 32'd36, 32'd0, 32'd0);
        chk("srl_b40", cdb_v_o, 32'h0800_0000);
        issue(5'd4, 1'b1, 4'd1, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
        chk("sltu", cdb_v_o, 32'd1);
        issue(5'd3, 1'b1, 4'd1, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0);
        chk("slt", cdb_v_o, 32'd0);
        issue(5'd10, 1'b0, 4'd1, 32'd7, 32'd0, 32'h1234_5000, 32'd0);
        chk("lui", cdb_v_o, 32'h1234_5000);
        issue(5'd11, 1'b0, 4'd1, 32'd0, 32'd0, 32'h10, 32'h1000);
        chk("auipc", cdb_v_o, 32'h1010);
        issue(5'd31, 1'b1, 4'd2, 32'd9, 32'd9, 32'd9, 32'd9);
        chk("unl_v",  cdb_v_o,            32'd0);
        chk("unl_br", {31'd0, cdb_br_o},  32'd0);
        chk("unl_q",  {28'd0, cdb_q_o},   32'd2);
        issue(5'd23, 1'b1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
`ifdef ALU_MUL_EN
        chk("mulhu", cdb_v_o, 32'hFFFF_FFFE);
`else
        chk("mulhu_off", cdb_v_o, 32'd0);
`endif
        tick();
        chk("drain_en", {31'd0, cdb_en_o}, 32'd0);

        // Fill without grant, overflow, then drain in order.
        cdb_gnt_i = 1'b0;
        issue(5'd10, 1'b0, 4'd1, 32'd0, 32'd0, 32'h11, 32'd0);
        issue(5'd10, 1'b0, 4'd2, 32'd0, 32'd0, 32'h22, 32'd0);
        chk("full_c2", {31'd0, alu_full_o}, 32'd0);
        issue(5'd10, 1'b0, 4'd3, 32'd0, 32'd0, 32'h33, 32'd0);
        chk("full_c3", {31'd0, alu_full_o}, 32'd1);
        chk("hold_q",  {28'd0, cdb_q_o},    32'd1);
        issue(5'd10, 1'b0, 4'd4, 32'd0, 32'd0, 32'h44, 32'd0);
        chk("full_c4", {31'd0, alu_full_o}, 32'd1);
        chk("ovf_c4",  {31'd0, ovf_o},      32'd0);
        issue(5'd10, 1'b0, 4'd5, 32'd0, 32'd0, 32'h55, 32'd0);
        chk("ovf_set", {31'd0, ovf_o},      32'd1);
        chk("ovf_hd",  {28'd0, cdb_q_o},    32'd1);
        cdb_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drn_q", {28'd0, cdb_q_o}, 32'(i + 1));
            chk("drn_v", cdb_v_o,          32'h11 * 32'(i + 1));
            tick();
        end
        chk("drn_end", {31'd0, cdb_en_o}, 32'd0);

        // Mispredict flush with a same-cycle issue.
        cdb_gnt_i = 1'b0;
        issue(5'd0, 1'b1, 4'd1, 32'd1, 32'd1, 32'd0, 32'd0);
        issue(5'd0, 1'b1, 4'd2, 32'd2, 32'd2, 32'd0, 32'd0);
        br_flag = 1'b1;
        issue(5'd0, 1'b1, 4'd3, 32'd3, 32'd3, 32'd0, 32'd0);
        br_flag = 1'b0;
        chk("fl_en",   {31'd0, cdb_en_o},   32'd0);
        chk("fl_full", {31'd0, alu_full_o}, 32'd0);
        chk("fl_q",    {28'd0, cdb_q_o},    32'd0);
        chk("fl_v",    cdb_v_o,             32'd0);
        chk("fl_ovf",  {31'd0, ovf_o},      32'd1);
        cdb_gnt_i = 1'b1;
        tick();
        chk("fl_stale", {31'd0, cdb_en_o}, 32'd0);

        do_reset();
        chk("rst_ovf_clr", {31'd0, ovf_o}, 32'd0);

        // Push and pop together at full occupancy: no drop.
        cdb_gnt_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(5'd10, 1'b0, 4'(i), 32'd0, 32'd0, 32'h11 * 32'(i), 32'd0);
        end
        cdb_gnt_i = 1'b1;
        issue(5'd10, 1'b0, 4'd5, 32'd0, 32'd0, 32'h55, 32'd0);
        chk("pp_ovf", {31'd0, ovf_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("pp_q", {28'd0, cdb_q_o}, 32'(i + 2));
            chk("pp_v", cdb_v_o,          32'h11 * 32'(i + 2));
            tick();
        end
        chk("pp_end", {31'd0, cdb_en_o}, 32'd0);

        // Disabled block ignores issue.
        en = 1'b0;
        issue(5'd0, 1'b1, 4'd1, 32'd1, 32'd1, 32'd0, 32'd0);
        en = 1'b1;
        chk("en0", {31'd0, cdb_en_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
